// File: rtl/spu_issue_stage_pkg.sv
// rtl/spu_issue_stage_pkg.sv - shared types, opcode encodings and latencies for the SPU issue stage
package spu_issue_stage_pkg;

    localparam int INST_WD  = 32;
    localparam int NUM_REGS = 128;
    localparam int CNT_W    = 3;

    typedef enum logic [3:0] {
        NOP, LNOP, AH, SFH, AI, ILA, IL, MPYA, SHLHI, CFLTS, ROTQBY, SHLQBY, LQD
    } Opcodes;

    typedef enum logic {PIPE_EVEN, PIPE_ODD} pipe_e;

    typedef enum logic [1:0] {ST_EMPTY, ST_PAIR, ST_SECOND} issue_state_e;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_RR, FMT_RRR, FMT_RI7, FMT_RI8, FMT_RI10, FMT_RI16, FMT_RI18
    } fmt_e;

    // Everything a pipe sees from one issued instruction
    typedef struct packed {
        Opcodes      opcode;
        logic [6:0]  ra;
        logic [6:0]  rb;
        logic [6:0]  rc;
        logic [6:0]  rt;
        logic [6:0]  i7;
        logic [7:0]  i8;
        logic [9:0]  i10;
        logic [15:0] i16;
        logic [17:0] i18;
    } issue_t;

    typedef struct packed {
        issue_t           iss;
        pipe_e            pipe;
        logic             use_ra;
        logic             use_rb;
        logic             use_rc;
        logic             wr_rt;
        logic             illegal;
        logic [CNT_W-1:0] stall_cnt;
    } decode_t;

    localparam logic [3:0]  OPC_MPYA   = 4'hC;
    localparam logic [10:0] OPC_NOP    = 11'h201;
    localparam logic [10:0] OPC_LNOP   = 11'h001;
    localparam logic [10:0] OPC_AH     = 11'h0C8;
    localparam logic [10:0] OPC_SFH    = 11'h048;
    localparam logic [10:0] OPC_ROTQBY = 11'h1DC;
    localparam logic [10:0] OPC_SHLQBY = 11'h1DF;
    localparam logic [10:0] OPC_SHLHI  = 11'h07F;
    localparam logic [9:0]  OPC_CFLTS  = 10'h1D8;
    localparam logic [7:0]  OPC_AI     = 8'h1C;
    localparam logic [7:0]  OPC_LQD    = 8'h34;
    localparam logic [8:0]  OPC_IL     = 9'h081;
    localparam logic [6:0]  OPC_ILA    = 7'h21;

    localparam logic [CNT_W-1:0] STALL_FX   = 3'd2;
    localparam logic [CNT_W-1:0] STALL_SHUF = 3'd4;
    localparam logic [CNT_W-1:0] STALL_LS   = 3'd6;
    localparam logic [CNT_W-1:0] STALL_FP   = 3'd7;

    function automatic logic [CNT_W-1:0] op_stall(input Opcodes op);
        case (op)
            AH, SFH, AI, ILA, IL:  return STALL_FX;
            SHLHI, ROTQBY, SHLQBY: return STALL_SHUF;
            LQD:                   return STALL_LS;
            MPYA, CFLTS:           return STALL_FP;
            default:               return '0;
        endcase
    endfunction

endpackage

// File: rtl/spu_decode.sv
// rtl/spu_decode.sv - combinational single-instruction decoder for the SPU issue stage
module spu_decode
    import spu_issue_stage_pkg::*;
(
    input  logic [INST_WD-1:0] i_inst,
    output decode_t            o_dec
);

    Opcodes w_op;
    pipe_e  w_pipe;
    fmt_e   w_fmt;
    logic   w_ill;

    // Opcode fields are prefix-free across formats, so test order only matters for MPYA's 4-bit code
    always_comb begin
        w_op   = NOP;
        w_pipe = PIPE_EVEN;
        w_fmt  = FMT_NONE;
        w_ill  = 1'b0;
        if (i_inst[31:28] == OPC_MPYA) begin
            w_op = MPYA; w_fmt = FMT_RRR;
        end else begin
            case (i_inst[31:21])
                OPC_NOP:    w_op = NOP;
                OPC_LNOP:   begin w_op = LNOP;   w_pipe = PIPE_ODD; end
                OPC_AH:     begin w_op = AH;     w_fmt = FMT_RR; end
                OPC_SFH:    begin w_op = SFH;    w_fmt = FMT_RR; end
                OPC_ROTQBY: begin w_op = ROTQBY; w_fmt = FMT_RR; w_pipe = PIPE_ODD; end
                OPC_SHLQBY: begin w_op = SHLQBY; w_fmt = FMT_RR; w_pipe = PIPE_ODD; end
                OPC_SHLHI:  begin w_op = SHLHI;  w_fmt = FMT_RI7; end
                default: begin
                    if (i_inst[31:22] == OPC_CFLTS) begin
                        w_op = CFLTS; w_fmt = FMT_RI8;
                    end else if (i_inst[31:24] == OPC_AI) begin
                        w_op = AI; w_fmt = FMT_RI10;
                    end else if (i_inst[31:24] == OPC_LQD) begin
                        w_op = LQD; w_fmt = FMT_RI10; w_pipe = PIPE_ODD;
                    end else if (i_inst[31:23] == OPC_IL) begin
                        w_op = IL; w_fmt = FMT_RI16;
                    end else if (i_inst[31:25] == OPC_ILA) begin
                        w_op = ILA; w_fmt = FMT_RI18;
                    end else begin
                        w_ill = 1'b1;
                    end
                end
            endcase
        end
    end

    // NOP, LNOP and illegal words carry no fields and never write a register
    always_comb begin
        o_dec            = '0;
        o_dec.iss.opcode = w_op;
        o_dec.pipe       = w_pipe;
        o_dec.illegal    = w_ill;
        o_dec.wr_rt      = (w_fmt != FMT_NONE);
        o_dec.stall_cnt  = (w_fmt != FMT_NONE) ? op_stall(w_op) : '0;
        case (w_fmt)
            FMT_RR: begin
                o_dec.iss.rb = i_inst[20:14]; o_dec.iss.ra = i_inst[13:7]; o_dec.iss.rt = i_inst[6:0];
                o_dec.use_ra = 1'b1; o_dec.use_rb = 1'b1;
            end
            FMT_RRR: begin
                o_dec.iss.rt = i_inst[27:21]; o_dec.iss.rb = i_inst[20:14];
                o_dec.iss.ra = i_inst[13:7];  o_dec.iss.rc = i_inst[6:0];
                o_dec.use_ra = 1'b1; o_dec.use_rb = 1'b1; o_dec.use_rc = 1'b1;
            end
            FMT_RI7: begin
                o_dec.iss.i7 = i_inst[20:14]; o_dec.iss.ra = i_inst[13:7]; o_dec.iss.rt = i_inst[6:0];
                o_dec.use_ra = 1'b1;
            end
            FMT_RI8: begin
                o_dec.iss.i8 = i_inst[21:14]; o_dec.iss.ra = i_inst[13:7]; o_dec.iss.rt = i_inst[6:0];
                o_dec.use_ra = 1'b1;
            end
            FMT_RI10: begin
                o_dec.iss.i10 = i_inst[23:14]; o_dec.iss.ra = i_inst[13:7]; o_dec.iss.rt = i_inst[6:0];
                o_dec.use_ra  = 1'b1;
            end
            FMT_RI16: begin
                o_dec.iss.i16 = i_inst[22:7]; o_dec.iss.rt = i_inst[6:0];
            end
            FMT_RI18: begin
                o_dec.iss.i18 = i_inst[24:7]; o_dec.iss.rt = i_inst[6:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/spu_issue_stage.sv
// rtl/spu_issue_stage.sv - SPU dual-issue stage: pair register, issue FSM, scoreboard, registered pipe outputs
module spu_issue_stage
    import spu_issue_stage_pkg::*;
#(
    parameter int INST_WD  = 32,
    parameter int NUM_REGS = 128,
    parameter int CNT_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_valid,
    output logic               inst_ready,
    input  logic [INST_WD-1:0] inst0,
    input  logic [INST_WD-1:0] inst1,
    output Opcodes             opcode_ep,
    output Opcodes             opcode_op,
    output logic [6:0]         ra_addr_ep,
    output logic [6:0]         rb_addr_ep,
    output logic [6:0]         rc_addr_ep,
    output logic [6:0]         rt_addr_ep,
    output logic [6:0]         ra_addr_op,
    output logic [6:0]         rb_addr_op,
    output logic [6:0]         rc_addr_op,
    output logic [6:0]         rt_addr_op,
    output logic [6:0]         imm_I7e,
    output logic [7:0]         imm_I8e,
    output logic [9:0]         imm_I10e,
    output logic [15:0]        imm_I16e,
    output logic [17:0]        imm_I18e,
    output logic [6:0]         imm_I7o,
    output logic [7:0]         imm_I8o,
    output logic [9:0]         imm_I10o,
    output logic [15:0]        imm_I16o,
    output logic [17:0]        imm_I18o,
    output logic               illegal_inst
);

    issue_state_e     r_state;
    logic [INST_WD-1:0] r_inst0, r_inst1;
    logic [CNT_W-1:0] r_sb [NUM_REGS];
    issue_t           r_ep, r_op;
    logic             r_illegal;

    decode_t      w_d0, w_d1;
    logic         w_rdy0, w_rdy1, w_raw, w_waw, w_dual;
    logic         w_iss0, w_iss1, w_drain, w_accept;
    issue_state_e w_next;
    issue_t       w_ep, w_op;

    spu_decode u_dec0 (.i_inst(r_inst0), .o_dec(w_d0));
    spu_decode u_dec1 (.i_inst(r_inst1), .o_dec(w_d1));

    assign w_rdy0 = !((w_d0.use_ra && r_sb[w_d0.iss.ra] != '0) ||
                      (w_d0.use_rb && r_sb[w_d0.iss.rb] != '0) ||
                      (w_d0.use_rc && r_sb[w_d0.iss.rc] != '0));
    assign w_rdy1 = !((w_d1.use_ra && r_sb[w_d1.iss.ra] != '0) ||
                      (w_d1.use_rb && r_sb[w_d1.iss.rb] != '0) ||
                      (w_d1.use_rc && r_sb[w_d1.iss.rc] != '0));
    assign w_raw  = w_d0.wr_rt && ((w_d1.use_ra && w_d1.iss.ra == w_d0.iss.rt) ||
                                   (w_d1.use_rb && w_d1.iss.rb == w_d0.iss.rt) ||
                                   (w_d1.use_rc && w_d1.iss.rc == w_d0.iss.rt));
    assign w_waw  = w_d0.wr_rt && w_d1.wr_rt && (w_d0.iss.rt == w_d1.iss.rt);
    assign w_dual = (w_d0.pipe != w_d1.pipe) && w_rdy0 && w_rdy1 && !w_raw && !w_waw;

    always_comb begin
        w_iss0 = 1'b0;
        w_iss1 = 1'b0;
        w_next = r_state;
        case (r_state)
            ST_PAIR: begin
                if (w_dual) begin
                    w_iss0 = 1'b1; w_iss1 = 1'b1; w_next = ST_EMPTY;
                end else if (w_rdy0) begin
                    w_iss0 = 1'b1; w_next = ST_SECOND;
                end
            end
            ST_SECOND: begin
                if (w_rdy1) begin
                    w_iss1 = 1'b1; w_next = ST_EMPTY;
                end
            end
            default: ;
        endcase
    end

    assign w_drain    = (w_next == ST_EMPTY) && (w_iss0 || w_iss1);
    assign inst_ready = (r_state == ST_EMPTY) || w_drain;
    assign w_accept   = inst_valid && inst_ready;

    // The split rules guarantee at most one issued instruction per pipe
    always_comb begin
        w_ep        = '0;
        w_ep.opcode = NOP;
        w_op        = '0;
        w_op.opcode = LNOP;
        if (w_iss0 && w_d0.pipe == PIPE_EVEN)      w_ep = w_d0.iss;
        else if (w_iss1 && w_d1.pipe == PIPE_EVEN) w_ep = w_d1.iss;
        if (w_iss0 && w_d0.pipe == PIPE_ODD)       w_op = w_d0.iss;
        else if (w_iss1 && w_d1.pipe == PIPE_ODD)  w_op = w_d1.iss;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_inst0     <= '0;
            r_inst1     <= '0;
            r_ep        <= '0;
            r_ep.opcode <= NOP;
            r_op        <= '0;
            r_op.opcode <= LNOP;
            r_illegal   <= 1'b0;
        end else begin
            r_state   <= w_accept ? ST_PAIR : w_next;
            if (w_accept) begin
                r_inst0 <= inst0;
                r_inst1 <= inst1;
            end
            r_ep      <= w_ep;
            r_op      <= w_op;
            r_illegal <= (w_iss0 && w_d0.illegal) || (w_iss1 && w_d1.illegal);
        end
    end

    // A fresh load wins over the per-cycle countdown on the same register
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!rst)
                r_sb[i] <= '0;
            else if (w_iss0 && w_d0.wr_rt && int'(w_d0.iss.rt) == i)
                r_sb[i] <= w_d0.stall_cnt;
            else if (w_iss1 && w_d1.wr_rt && int'(w_d1.iss.rt) == i)
                r_sb[i] <= w_d1.stall_cnt;
            else if (r_sb[i] != '0)
                r_sb[i] <= r_sb[i] - 1'b1;
        end
    end

    assign opcode_ep    = r_ep.opcode;
    assign ra_addr_ep   = r_ep.ra;
    assign rb_addr_ep   = r_ep.rb;
    assign rc_addr_ep   = r_ep.rc;
    assign rt_addr_ep   = r_ep.rt;
    assign imm_I7e      = r_ep.i7;
    assign imm_I8e      = r_ep.i8;
    assign imm_I10e     = r_ep.i10;
    assign imm_I16e     = r_ep.i16;
    assign imm_I18e     = r_ep.i18;
    assign opcode_op    = r_op.opcode;
    assign ra_addr_op   = r_op.ra;
    assign rb_addr_op   = r_op.rb;
    assign rc_addr_op   = r_op.rc;
    assign rt_addr_op   = r_op.rt;
    assign imm_I7o      = r_op.i7;
    assign imm_I8o      = r_op.i8;
    assign imm_I10o     = r_op.i10;
    assign imm_I16o     = r_op.i16;
    assign imm_I18o     = r_op.i18;
    assign illegal_inst = r_illegal;

endmodule

// File: tb/tb_spu_issue_stage.sv
// tb/tb_spu_issue_stage.sv - randomized and directed checks of spu_issue_stage against a queue-based model
module tb_spu_issue_stage;
    import spu_issue_stage_pkg::*;

    localparam int K_AH = 0, K_SFH = 1, K_AI = 2, K_ILA = 3, K_IL = 4, K_MPYA = 5, K_SHLHI = 6,
                   K_CFLTS = 7, K_ROTQBY = 8, K_SHLQBY = 9, K_LQD = 10, K_NOP = 11, K_LNOP = 12, K_ILL = 13;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [31:0] inst0 = '0, inst1 = '0;
    Opcodes      opcode_ep, opcode_op;
    logic [6:0]  ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep;
    logic [6:0]  ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op;
    logic [6:0]  imm_I7e, imm_I7o;
    logic [7:0]  imm_I8e, imm_I8o;
    logic [9:0]  imm_I10e, imm_I10o;
    logic [15:0] imm_I16e, imm_I16o;
    logic [17:0] imm_I18e, imm_I18o;
    logic        illegal_inst;

    spu_issue_stage dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst0(inst0), .inst1(inst1), .opcode_ep(opcode_ep), .opcode_op(opcode_op),
        .ra_addr_ep(ra_addr_ep), .rb_addr_ep(rb_addr_ep), .rc_addr_ep(rc_addr_ep), .rt_addr_ep(rt_addr_ep),
        .ra_addr_op(ra_addr_op), .rb_addr_op(rb_addr_op), .rc_addr_op(rc_addr_op), .rt_addr_op(rt_addr_op),
        .imm_I7e(imm_I7e), .imm_I8e(imm_I8e), .imm_I10e(imm_I10e), .imm_I16e(imm_I16e), .imm_I18e(imm_I18e),
        .imm_I7o(imm_I7o), .imm_I8o(imm_I8o), .imm_I10o(imm_I10o), .imm_I16o(imm_I16o), .imm_I18o(imm_I18o),
        .illegal_inst(illegal_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        Opcodes      op;
        bit          odd;
        bit          ill;
        bit          wr;
        int          stall;
        int          s0, s1, s2;
        int          rt;
        logic [86:0] f;
    } rec_t;

    int          checks = 0;
    int          errors = 0;
    rec_t        pend[$];
    int          sb[128];
    Opcodes      e_ep = NOP, e_op = LNOP;
    logic [86:0] e_epf = '0, e_opf = '0;
    bit          e_ill = 1'b0;
    logic [31:0] g_w0, g_w1;
    rec_t        g_r0, g_r1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void enc(input int k, input logic [6:0] ra, rb, rc, rt, input logic [17:0] im,
                                output logic [31:0] w, output rec_t r);
        logic [6:0]  fa, fb, fc, ft, i7;
        logic [7:0]  i8;
        logic [9:0]  i10;
        logic [15:0] i16;
        logic [17:0] i18;
        fa = '0; fb = '0; fc = '0; ft = rt; i7 = '0; i8 = '0; i10 = '0; i16 = '0; i18 = '0;
        r.op = NOP; r.odd = 1'b0; r.ill = 1'b0; r.wr = 1'b1; r.stall = 2;
        r.s0 = -1; r.s1 = -1; r.s2 = -1; r.rt = int'(rt);
        case (k)
            K_AH, K_SFH, K_ROTQBY, K_SHLQBY: begin
                case (k)
                    K_AH:    begin r.op = AH;  w = {11'h0C8, rb, ra, rt}; end
                    K_SFH:   begin r.op = SFH; w = {11'h048, rb, ra, rt}; end
                    K_ROTQBY: begin r.op = ROTQBY; r.odd = 1'b1; r.stall = 4; w = {11'h1DC, rb, ra, rt}; end
                    default: begin r.op = SHLQBY; r.odd = 1'b1; r.stall = 4; w = {11'h1DF, rb, ra, rt}; end
                endcase
                r.s0 = int'(ra); r.s1 = int'(rb); fa = ra; fb = rb;
            end
            K_AI:    begin r.op = AI; w = {8'h1C, im[9:0], ra, rt}; r.s0 = int'(ra); fa = ra; i10 = im[9:0]; end
            K_LQD:   begin r.op = LQD; r.odd = 1'b1; r.stall = 6; w = {8'h34, im[9:0], ra, rt};
                           r.s0 = int'(ra); fa = ra; i10 = im[9:0]; end
            K_ILA:   begin r.op = ILA; w = {7'h21, im, rt}; i18 = im; end
            K_IL:    begin r.op = IL; w = {9'h081, im[15:0], rt}; i16 = im[15:0]; end
            K_MPYA:  begin r.op = MPYA; r.stall = 7; w = {4'hC, rt, rb, ra, rc};
                           r.s0 = int'(ra); r.s1 = int'(rb); r.s2 = int'(rc); fa = ra; fb = rb; fc = rc; end
            K_SHLHI: begin r.op = SHLHI; r.stall = 4; w = {11'h07F, im[6:0], ra, rt};
                           r.s0 = int'(ra); fa = ra; i7 = im[6:0]; end
            K_CFLTS: begin r.op = CFLTS; r.stall = 7; w = {10'h1D8, im[7:0], ra, rt};
                           r.s0 = int'(ra); fa = ra; i8 = im[7:0]; end
            K_NOP:   begin w = {11'h201, 21'h0}; r.wr = 1'b0; r.rt = -1; ft = '0; end
            K_LNOP:  begin r.op = LNOP; r.odd = 1'b1; w = {11'h001, 21'h0}; r.wr = 1'b0; r.rt = -1; ft = '0; end
            default: begin w = 32'hFFFF_FFFF; r.ill = 1'b1; r.wr = 1'b0; r.rt = -1; ft = '0; end
        endcase
        r.f = {fa, fb, fc, ft, i7, i8, i10, i16, i18};
    endfunction

    function automatic bit rdy(input rec_t r);
        return !((r.s0 >= 0 && sb[r.s0] != 0) || (r.s1 >= 0 && sb[r.s1] != 0) ||
                 (r.s2 >= 0 && sb[r.s2] != 0));
    endfunction

    function automatic logic [6:0] rreg();
        if ($urandom_range(0, 9) == 0) return 7'(127 - $urandom_range(0, 2));
        return 7'($urandom_range(0, 5));
    endfunction

    // One clock: check last cycle's outputs, drive, predict this cycle's decision
    task automatic step(input bit v, input bit do_rst);
        rec_t iss[$];
        rec_t a, b;
        @(negedge clk);
        chk("opcode_ep", opcode_ep, e_ep);
        chk("opcode_op", opcode_op, e_op);
        chk("fields_ep", {ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep,
                          imm_I7e, imm_I8e, imm_I10e, imm_I16e, imm_I18e}, e_epf);
        chk("fields_op", {ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op,
                          imm_I7o, imm_I8o, imm_I10o, imm_I16o, imm_I18o}, e_opf);
        chk("illegal_inst", illegal_inst, e_ill);
        rst = !do_rst; inst_valid = v; inst0 = g_w0; inst1 = g_w1;
        #1;
        e_ep = NOP; e_op = LNOP; e_epf = '0; e_opf = '0; e_ill = 1'b0;
        if (do_rst) begin
            pend.delete();
            foreach (sb[i]) sb[i] = 0;
            return;
        end
        if (pend.size() == 2) begin
            a = pend[0]; b = pend[1];
            if (a.odd != b.odd && rdy(a) && rdy(b) &&
                !(a.wr && (b.s0 == a.rt || b.s1 == a.rt || b.s2 == a.rt)) &&
                !(a.wr && b.wr && a.rt == b.rt)) begin
                iss.push_back(a); iss.push_back(b);
            end else if (rdy(a)) iss.push_back(a);
        end else if (pend.size() == 1 && rdy(pend[0])) iss.push_back(pend[0]);
        repeat (iss.size()) void'(pend.pop_front());
        chk("inst_ready", inst_ready, pend.size() == 0);
        foreach (sb[i]) if (sb[i] > 0) sb[i]--;
        foreach (iss[j]) begin
            if (iss[j].wr) sb[iss[j].rt] = iss[j].stall;
            if (iss[j].odd) begin e_op = iss[j].op; e_opf = iss[j].f; end
            else            begin e_ep = iss[j].op; e_epf = iss[j].f; end
            e_ill |= iss[j].ill;
        end
        if (v && pend.size() == 0) begin
            pend.push_back(g_r0); pend.push_back(g_r1);
        end
    endtask

    task automatic pair(input int k0, a0, b0, c0, t0, input int k1, a1, b1, c1, t1, input int idle);
        enc(k0, 7'(a0), 7'(b0), 7'(c0), 7'(t0), 18'h2A5A5, g_w0, g_r0);
        enc(k1, 7'(a1), 7'(b1), 7'(c1), 7'(t1), 18'h3FFFF, g_w1, g_r1);
        step(1'b1, 1'b0);
        repeat (idle) step(1'b0, 1'b0);
    endtask

    initial begin
        foreach (sb[i]) sb[i] = 0;
        enc(K_NOP, '0, '0, '0, '0, '0, g_w0, g_r0);
        enc(K_LNOP, '0, '0, '0, '0, '0, g_w1, g_r1);
        repeat (2) @(negedge clk);
        chk("rst_ready", inst_ready, 1'b1);

        pair(K_AH, 1, 2, 0, 3,   K_ROTQBY, 4, 5, 0, 6,   3);
        pair(K_AH, 1, 2, 0, 3,   K_SFH, 1, 2, 0, 8,      4);
        pair(K_AH, 1, 2, 0, 3,   K_SHLQBY, 3, 4, 0, 7,   6);
        pair(K_AH, 1, 2, 0, 9,   K_LQD, 5, 0, 0, 9,      8);
        pair(K_ILL, 0, 0, 0, 0,  K_LQD, 12, 0, 0, 11,    3);
        pair(K_MPYA, 1, 2, 3, 20, K_SHLQBY, 20, 4, 0, 21, 2);
        step(1'b0, 1'b1);
        pair(K_AH, 20, 20, 0, 22, K_ROTQBY, 20, 1, 0, 23, 3);
        pair(K_CFLTS, 127, 0, 0, 126, K_ILA, 0, 0, 0, 127, 10);

        for (int n = 0; n < 600; n++) begin
            enc($urandom_range(0, 13), rreg(), rreg(), rreg(), rreg(), 18'($urandom), g_w0, g_r0);
            enc($urandom_range(0, 13), rreg(), rreg(), rreg(), rreg(), 18'($urandom), g_w1, g_r1);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
        end
        repeat (12) step(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
